// File: rtl/phys_reg_free_list.sv
// Physical-register free list with the committed (retirement) rename map.
// Rename allocates up to two PRs per cycle from head. ROB retirement pushes
// the displaced PR at tail, advances commit_head, and updates the committed
// map. A flush rewinds head to the committed point, which reclaims every
// speculatively allocated PR in one step.
//
// Handshake: alloc_req is a per-slot request held by rename for the cycle;
// alloc_grant answers in the same cycle and is either exactly alloc_req or
// 2'b00. A slot owns the PR on its alloc_phy output only when its grant bit
// is set. There is no partial grant and no back-pressure on retirement.
module phys_reg_free_list #(
  parameter int NUM_PHY   = 64,
  parameter int PHY_WIDTH = 6,
  parameter int NUM_ARCH  = 32,
  parameter int FL_DEPTH  = 32,
  parameter int PTR_W     = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [1:0]                    alloc_req,
  output logic [1:0]                    alloc_grant,
  output logic [PHY_WIDTH-1:0]          alloc_phy_0,
  output logic [PHY_WIDTH-1:0]          alloc_phy_1,
  input  logic                          retire_pr_valid,
  input  logic [4:0]                    rd_arch_commit,
  input  logic [PHY_WIDTH-1:0]          rd_phy_old_commit,
  input  logic [PHY_WIDTH-1:0]          rd_phy_new_commit,
  output logic [PTR_W:0]                free_count,
  output logic                          fl_empty,
  output logic [NUM_ARCH*PHY_WIDTH-1:0] committed_map_flat
);

  // Free-list storage and the committed arch->phys map.
  logic [PHY_WIDTH-1:0] fl   [FL_DEPTH];
  logic [PHY_WIDTH-1:0] cmap [NUM_ARCH];

  // Pointers carry one wrap bit above the index so full and empty differ.
  logic [PTR_W:0]   head;
  logic [PTR_W:0]   tail;
  logic [PTR_W:0]   commit_head;

  logic [1:0]       need;
  logic [PTR_W:0]   need_ext;
  logic             ok;
  logic             ret;
  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] head_idx_nxt;

  // The physical register file size must cover the architectural set plus
  // the free list; a mismatch is a configuration error.
  if (NUM_PHY != NUM_ARCH + FL_DEPTH) begin : g_bad_cfg
    $error("phys_reg_free_list: NUM_PHY must equal NUM_ARCH + FL_DEPTH");
  end

  assign free_count = tail - head;
  assign fl_empty   = (free_count == '0);

  // Retire to x0 never had an allocation behind it, so it is dropped.
  assign ret = retire_pr_valid && (rd_arch_commit != 5'd0);

  // Allocation decision and PR selection, all in the request cycle.
  always_comb begin
    need         = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
    need_ext     = {{(PTR_W-1){1'b0}}, need};
    ok           = !flush && (free_count >= need_ext);
    alloc_grant  = ok ? alloc_req : 2'b00;
    head_idx     = head[PTR_W-1:0];
    head_idx_nxt = head_idx + 1'b1;
    alloc_phy_0  = fl[head_idx];
    // A lone slot-1 request takes the head entry; otherwise slot 1 gets
    // the entry after slot 0 so program order is kept.
    alloc_phy_1  = (alloc_req == 2'b10) ? fl[head_idx] : fl[head_idx_nxt];
  end

  // Pointer, free-list and committed-map update; rst clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl[i] <= PHY_WIDTH'(NUM_ARCH + i);
      end
      for (int i = 0; i < NUM_ARCH; i++) begin
        cmap[i] <= PHY_WIDTH'(i);
      end
      head        <= '0;
      commit_head <= '0;
      tail        <= (PTR_W+1)'(FL_DEPTH);
    end else begin
      if (ret) begin
        fl[tail[PTR_W-1:0]]  <= rd_phy_old_commit;
        tail                 <= tail + 1'b1;
        commit_head          <= commit_head + 1'b1;
        cmap[rd_arch_commit] <= rd_phy_new_commit;
      end
      // Flush rewinds to the committed point including this cycle's retire.
      if (flush) begin
        head <= commit_head + {{PTR_W{1'b0}}, ret};
      end else if (ok) begin
        head <= head + need_ext;
      end
    end
  end

  // Flatten the committed map for RAT recovery.
  for (genvar g = 0; g < NUM_ARCH; g++) begin : g_cmap_flat
    assign committed_map_flat[g*PHY_WIDTH +: PHY_WIDTH] = cmap[g];
  end

  // A full free list means nothing is allocated and uncommitted, so a
  // retire there would overflow the list.
  a_no_overflow_retire : assert property (
    @(posedge clk) disable iff (rst)
    !(ret && (free_count == (PTR_W+1)'(FL_DEPTH)))
  );

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: the driver applies one cycle of
// inputs and queues the expected outputs for that cycle; a monitor on the
// falling edge pops and compares them.
module tb_phys_reg_free_list;

  localparam int PHY_WIDTH = 6;
  localparam int NUM_ARCH  = 32;
  localparam int PTR_W     = 5;

  // Output selectors for scoreboard entries.
  localparam int S_GRANT = 0;
  localparam int S_PHY0  = 1;
  localparam int S_PHY1  = 2;
  localparam int S_FREE  = 3;
  localparam int S_EMPTY = 4;
  localparam int S_CMAP  = 5;

  typedef struct {
    int          cyc;
    int          sel;
    int          arch;
    logic [31:0] val;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush;
  logic [1:0]                    alloc_req;
  logic [1:0]                    alloc_grant;
  logic [PHY_WIDTH-1:0]          alloc_phy_0;
  logic [PHY_WIDTH-1:0]          alloc_phy_1;
  logic                          retire_pr_valid;
  logic [4:0]                    rd_arch_commit;
  logic [PHY_WIDTH-1:0]          rd_phy_old_commit;
  logic [PHY_WIDTH-1:0]          rd_phy_new_commit;
  logic [PTR_W:0]                free_count;
  logic                          fl_empty;
  logic [NUM_ARCH*PHY_WIDTH-1:0] committed_map_flat;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  phys_reg_free_list dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .alloc_req          (alloc_req),
    .alloc_grant        (alloc_grant),
    .alloc_phy_0        (alloc_phy_0),
    .alloc_phy_1        (alloc_phy_1),
    .retire_pr_valid    (retire_pr_valid),
    .rd_arch_commit     (rd_arch_commit),
    .rd_phy_old_commit  (rd_phy_old_commit),
    .rd_phy_new_commit  (rd_phy_new_commit),
    .free_count         (free_count),
    .fl_empty           (fl_empty),
    .committed_map_flat (committed_map_flat)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Move to the drive window of the next cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic fl_in, input logic rv,
                       input int arch, input int old_pr, input int new_pr);
    alloc_req         = req;
    flush             = fl_in;
    retire_pr_valid   = rv;
    rd_arch_commit    = 5'(arch);
    rd_phy_old_commit = PHY_WIDTH'(old_pr);
    rd_phy_new_commit = PHY_WIDTH'(new_pr);
  endtask

  task automatic expect_out(input int sel, input int arch, input int val);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.arch = arch;
    e.val  = 32'(val);
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      string       nm;
      e = exp_q.pop_front();
      case (e.sel)
        S_GRANT: begin act = 32'(alloc_grant); nm = "alloc_grant"; end
        S_PHY0:  begin act = 32'(alloc_phy_0); nm = "alloc_phy_0"; end
        S_PHY1:  begin act = 32'(alloc_phy_1); nm = "alloc_phy_1"; end
        S_FREE:  begin act = 32'(free_count);  nm = "free_count";  end
        S_EMPTY: begin act = 32'(fl_empty);    nm = "fl_empty";    end
        default: begin
          act = 32'(committed_map_flat[e.arch*PHY_WIDTH +: PHY_WIDTH]);
          nm  = $sformatf("cmap[%0d]", e.arch);
        end
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, cyc, act, e.val);
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    drive(2'b00, 1'b0, 1'b0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset state.
    drive(2'b11, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 32);
    expect_out(S_EMPTY, 0, 0);
    expect_out(S_CMAP, 5, 5);
    expect_out(S_GRANT, 0, 3);
    expect_out(S_PHY0, 0, 32);
    expect_out(S_PHY1, 0, 33);

    // 2: lone slot-1 request takes the head PR.
    next_cycle();
    drive(2'b10, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 30);
    expect_out(S_GRANT, 0, 2);
    expect_out(S_PHY1, 0, 34);
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 29);
    expect_out(S_GRANT, 0, 0);

    // 3: drain to a single free PR (head 3 -> 31).
    for (int k = 0; k < 14; k++) begin
      next_cycle();
      drive(2'b11, 1'b0, 1'b0, 0, 0, 0);
      expect_out(S_GRANT, 0, 3);
      expect_out(S_PHY0, 0, 35 + 2*k);
      expect_out(S_PHY1, 0, 36 + 2*k);
      expect_out(S_FREE, 0, 29 - 2*k);
    end
    next_cycle();
    drive(2'b11, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 1);
    expect_out(S_GRANT, 0, 0);
    next_cycle();
    drive(2'b01, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 1);
    expect_out(S_GRANT, 0, 1);
    expect_out(S_PHY0, 0, 63);
    next_cycle();
    drive(2'b01, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 0);
    expect_out(S_EMPTY, 0, 1);
    expect_out(S_GRANT, 0, 0);

    // 4: retirement frees PR 7, reused after the index wraps.
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 7, 7, 32);
    expect_out(S_FREE, 0, 0);
    expect_out(S_CMAP, 7, 7);
    next_cycle();
    drive(2'b01, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 1);
    expect_out(S_EMPTY, 0, 0);
    expect_out(S_CMAP, 7, 32);
    expect_out(S_GRANT, 0, 1);
    expect_out(S_PHY0, 0, 7);
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 0);

    // Asynchronous reset mid-operation restores reset state at once.
    next_cycle();
    rst = 1'b1;
    #1;
    expect_out(S_FREE, 0, 32);
    expect_out(S_CMAP, 7, 7);
    expect_out(S_PHY0, 0, 32);
    next_cycle();
    rst = 1'b0;

    // 5: allocate 32,33,34; retire the first; flush rewinds to 33.
    drive(2'b11, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_GRANT, 0, 3);
    expect_out(S_PHY0, 0, 32);
    expect_out(S_PHY1, 0, 33);
    next_cycle();
    drive(2'b01, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_PHY0, 0, 34);
    expect_out(S_FREE, 0, 30);
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 1, 1, 32);
    expect_out(S_FREE, 0, 29);
    next_cycle();
    drive(2'b01, 1'b1, 1'b0, 0, 0, 0);
    expect_out(S_GRANT, 0, 0);
    expect_out(S_FREE, 0, 30);
    expect_out(S_CMAP, 1, 32);
    next_cycle();
    drive(2'b01, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 32);
    expect_out(S_GRANT, 0, 1);
    expect_out(S_PHY0, 0, 33);

    // 6: flush + retire + alloc in one cycle: grant blocked, head lands
    // on the post-retire committed point.
    next_cycle();
    drive(2'b11, 1'b1, 1'b1, 2, 2, 33);
    expect_out(S_GRANT, 0, 0);
    expect_out(S_FREE, 0, 31);
    next_cycle();
    drive(2'b01, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 32);
    expect_out(S_CMAP, 2, 33);
    expect_out(S_PHY0, 0, 34);
    expect_out(S_GRANT, 0, 1);

    // Retire to x0 is ignored.
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 0, 5, 40);
    expect_out(S_FREE, 0, 31);
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 31);
    expect_out(S_CMAP, 0, 0);

    // Simultaneous two-wide alloc and retire nets -1.
    next_cycle();
    drive(2'b11, 1'b0, 1'b1, 3, 3, 35);
    expect_out(S_GRANT, 0, 3);
    expect_out(S_PHY0, 0, 35);
    expect_out(S_PHY1, 0, 36);
    expect_out(S_FREE, 0, 31);
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 0, 0, 0);
    expect_out(S_FREE, 0, 30);
    expect_out(S_CMAP, 3, 35);

    // Let the monitor drain, bounded.
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) next_cycle();
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
